line_write_merger: RTL and testbench

LINE_WRITE_MERGER -- requirements
Module: line_write_merger

---
 rtl/lwm_pkg.sv | 22 ++
 rtl/word_strb_merge.sv | 30 +++
 rtl/line_write_merger.sv | 115 +++++++++++
 tb/tb_line_write_merger.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lwm_pkg.sv
// Shared types and constants for the line write merger: FSM state encoding
// and the word/line/mask typedefs for a 256-bit line of eight 32-bit words.
package lwm_pkg;

  localparam int WORD_W         = 32;
  localparam int WORDS_PER_LINE = 8;
  localparam int OFFSET_W       = 3;
  localparam int LINE_ADDR_W    = 27;
  localparam int BYTES_PER_WORD = WORD_W / 8;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  typedef logic [WORD_W-1:0]                         word_t;
  typedef logic [WORD_W*WORDS_PER_LINE-1:0]          line_t;
  typedef logic [BYTES_PER_WORD*WORDS_PER_LINE-1:0]  line_mask_t;
  typedef logic [LINE_ADDR_W-1:0]                    line_addr_t;

endpackage

// File: rtl/word_strb_merge.sv
// Byte-strobe merge of one incoming store word into one word lane of the line
// buffer; unenabled or unstrobed bytes keep their previous contents and mask.
module word_strb_merge #(
  parameter int WORD_W = 32
) (
  input  logic                en,
  input  logic [WORD_W-1:0]   old_data,
  input  logic [WORD_W/8-1:0] old_mask,
  input  logic [WORD_W-1:0]   new_data,
  input  logic [WORD_W/8-1:0] strb,
  output logic [WORD_W-1:0]   merged_data,
  output logic [WORD_W/8-1:0] merged_mask
);

  localparam int BYTES = WORD_W / 8;

  // NOTE: every output gets a default before the loop so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    merged_data = old_data;
    merged_mask = old_mask;
    for (int b = 0; b < BYTES; b++) begin
      if (en && strb[b]) begin
        merged_data[8*b +: 8] = new_data[8*b +: 8];
        merged_mask[b]        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/line_write_merger.sv
// Coalesces word stores into one cache-line write: fills a line buffer until
// every byte is written, a store to another line arrives, or flush is raised.
module line_write_merger
  import lwm_pkg::*;
#(
  parameter int WORD_W         = lwm_pkg::WORD_W,
  parameter int WORDS_PER_LINE = lwm_pkg::WORDS_PER_LINE,
  parameter int ADDR_W         = 32
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 wr_valid,
  output logic                                 wr_ready,
  input  logic [ADDR_W-1:0]                    wr_addr,
  input  logic [WORD_W-1:0]                    wr_data,
  input  logic [WORD_W/8-1:0]                  wr_strb,
  input  logic                                 flush,
  output logic                                 line_valid,
  input  logic                                 line_ready,
  output logic [ADDR_W-$clog2(WORDS_PER_LINE*WORD_W/8)-1:0] line_addr,
  output logic [WORD_W*WORDS_PER_LINE-1:0]     line_data,
  output logic [WORDS_PER_LINE*WORD_W/8-1:0]   line_wmask,
  output logic                                 idle
);

  localparam int BYTES      = WORD_W / 8;
  localparam int BYTE_OFF_W = $clog2(BYTES);
  localparam int OFF_W      = $clog2(WORDS_PER_LINE);
  localparam int LA_LSB     = BYTE_OFF_W + OFF_W;
  localparam int LA_W       = ADDR_W - LA_LSB;
  localparam int DATA_W     = WORD_W * WORDS_PER_LINE;
  localparam int MASK_W     = BYTES * WORDS_PER_LINE;

  state_t              state_q, state_d;
  logic [LA_W-1:0]     addr_q;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [MASK_W-1:0]   mask_q, mask_d;
  logic [OFF_W-1:0]    offset;
  logic                line_match;
  logic                accept;
  logic                mask_full;
  logic                unused_addr_bits;

  assign offset           = wr_addr[BYTE_OFF_W +: OFF_W];
  assign line_match       = (wr_addr[ADDR_W-1:LA_LSB] == addr_q);
  assign unused_addr_bits = ^wr_addr[BYTE_OFF_W-1:0];

  assign wr_ready = (state_q == ST_EMPTY) ||
                    ((state_q == ST_FILL) && !(wr_valid && !line_match));
  assign accept   = wr_valid && wr_ready;

  // Word 0 sits in the most significant lane to match the read-side select.
  for (genvar k = 0; k < WORDS_PER_LINE; k++) begin : g_lane
    localparam int LANE = WORDS_PER_LINE - 1 - k;
    word_strb_merge #(.WORD_W(WORD_W)) u_merge (
      .en          (accept && (offset == OFF_W'(k))),
      .old_data    (data_q[LANE*WORD_W +: WORD_W]),
      .old_mask    (mask_q[LANE*BYTES +: BYTES]),
      .new_data    (wr_data),
      .strb        (wr_strb),
      .merged_data (data_d[LANE*WORD_W +: WORD_W]),
      .merged_mask (mask_d[LANE*BYTES +: BYTES])
    );
  end

  assign mask_full = &mask_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept) state_d = mask_full ? ST_DRAIN : ST_FILL;
      end
      ST_FILL: begin
        // A matching write alongside flush is already folded into data_d.
        if ((accept && mask_full) || flush || (wr_valid && !line_match))
          state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (line_ready) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      addr_q  <= '0;
      // NOTE: the line buffer is reset because discarded partial lines must
      // not leak stale bytes, and unwritten bytes must read as zero.
      data_q  <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        data_q <= data_d;
        mask_q <= mask_d;
        if (state_q == ST_EMPTY) addr_q <= wr_addr[ADDR_W-1:LA_LSB];
      end else if ((state_q == ST_DRAIN) && line_ready) begin
        data_q <= '0;
        mask_q <= '0;
      end
    end
  end

  assign line_valid = (state_q == ST_DRAIN);
  assign line_addr  = addr_q;
  assign line_data  = data_q;
  assign line_wmask = mask_q;
  assign idle       = (state_q == ST_EMPTY);

endmodule

// File: tb/tb_line_write_merger.sv
// Directed bench for line_write_merger: a byte-level model builds expected
// lines into a scoreboard queue that is popped as each line is drained.
module tb_line_write_merger;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_valid;
  logic          wr_ready;
  logic [31:0]   wr_addr;
  logic [31:0]   wr_data;
  logic [3:0]    wr_strb;
  logic          flush;
  logic          line_valid;
  logic          line_ready;
  logic [26:0]   line_addr;
  logic [255:0]  line_data;
  logic [31:0]   line_wmask;
  logic          idle;

  typedef struct {
    logic [26:0]  addr;
    logic [255:0] data;
    logic [31:0]  mask;
  } line_exp_t;

  line_exp_t    sb[$];
  logic [26:0]  m_addr;
  logic [255:0] m_data;
  logic [31:0]  m_mask;
  int           total  = 0;
  int           passed = 0;
  int           fails  = 0;

  always #5 clk = ~clk;

  line_write_merger dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_strb    (wr_strb),
    .flush      (flush),
    .line_valid (line_valid),
    .line_ready (line_ready),
    .line_addr  (line_addr),
    .line_data  (line_data),
    .line_wmask (line_wmask),
    .idle       (idle)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_data = '0;
    m_mask = '0;
  endtask

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int k;
    k = int'(addr[4:2]);
    if (m_mask == '0) m_addr = addr[31:5];
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        m_data[32*(7-k) + 8*b +: 8] = data[8*b +: 8];
        m_mask[4*(7-k) + b]         = 1'b1;
      end
    end
  endtask

  task automatic push_line();
    line_exp_t e;
    e.addr = m_addr;
    e.data = m_data;
    e.mask = m_mask;
    sb.push_back(e);
    model_clear();
  endtask

  // Offers one store (optionally with flush) and waits a bounded time for it to be taken.
  task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic with_flush);
    int cyc;
    @(negedge clk);
    wr_valid = 1'b1;
    wr_addr  = addr;
    wr_data  = data;
    wr_strb  = strb;
    flush    = with_flush;
    #1;
    cyc = 0;
    while (!wr_ready && cyc < 50) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check({tag, "_accept"}, wr_ready, 1'b1);
    if (m_mask == '0 && strb == '0) m_addr = addr[31:5];
    model_write(addr, data, strb);
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic pulse_flush();
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  // Waits for a presented line, compares it with the scoreboard head, then hands it off.
  task automatic expect_line(input string tag);
    int        cyc;
    line_exp_t e;
    cyc = 0;
    @(negedge clk);
    while (!line_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (!line_valid) begin
      check({tag, "_timeout"}, line_valid, 1'b1);
    end else if (sb.size() == 0) begin
      check({tag, "_unexpected_line"}, line_valid, 1'b0);
    end else begin
      e = sb.pop_front();
      check({tag, "_addr"}, line_addr, e.addr);
      check({tag, "_data"}, line_data, e.data);
      check({tag, "_mask"}, line_wmask, e.mask);
      line_ready = 1'b1;
      @(posedge clk);
      #1;
      line_ready = 1'b0;
      check({tag, "_idle_after"}, idle, 1'b1);
      check({tag, "_mask_cleared"}, line_wmask, 32'h0);
    end
  endtask

  initial begin
    logic [255:0] held;
    logic         seen;
    rst_n      = 1'b0;
    wr_valid   = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    wr_strb    = '0;
    flush      = 1'b0;
    line_ready = 1'b0;
    m_addr     = '0;
    model_clear();

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_line_valid", line_valid, 1'b0);
    check("rst_line_addr", line_addr, 27'h0);
    check("rst_line_data", line_data, 256'h0);
    check("rst_line_wmask", line_wmask, 32'h0);
    check("rst_idle", idle, 1'b1);
    rst_n = 1'b1;
    #1;
    check("rst_wr_ready", wr_ready, 1'b1);

    // Flush while EMPTY is ignored.
    pulse_flush();
    check("flush_empty_idle", idle, 1'b1);
    check("flush_empty_no_line", line_valid, 1'b0);

    // Full line of eight words; drain held off five cycles.
    for (int i = 0; i < 8; i++)
      do_write("full", 32'h1000 + 32'(4*i), 32'hA0 + 32'(i), 4'hF, 1'b0);
    push_line();
    #1;
    check("full_valid_after_edge", line_valid, 1'b1);
    check("full_word0", line_data[255:224], 32'hA0);
    check("full_word7", line_data[31:0], 32'hA7);
    check("full_addr_const", line_addr, 27'h080);
    check("full_mask_const", line_wmask, 32'hFFFF_FFFF);
    held = line_data;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", line_valid, 1'b1);
      check("hold_data", line_data, held);
      check("hold_wr_ready", wr_ready, 1'b0);
    end
    expect_line("full");

    // Partial strobes then flush.
    do_write("strb5", 32'h2008, 32'h1122_3344, 4'h5, 1'b0);
    pulse_flush();
    push_line();
    #1;
    check("strb5_word2", line_data[191:160], 32'h0022_0044);
    check("strb5_mask_const", line_wmask, 32'h0050_0000);
    expect_line("strb5");

    // Store to another line forces a drain and is held until EMPTY.
    do_write("miss_a", 32'h3000, 32'hDEAD_BEEF, 4'hF, 1'b0);
    push_line();
    @(negedge clk);
    wr_valid = 1'b1;
    wr_addr  = 32'h4000;
    wr_data  = 32'hCAFE_F00D;
    wr_strb  = 4'hF;
    #1;
    check("miss_held_ready", wr_ready, 1'b0);
    @(posedge clk);
    #1;
    check("miss_drain_valid", line_valid, 1'b1);
    check("miss_drain_ready", wr_ready, 1'b0);
    check("miss_mask_const", line_wmask, 32'hF000_0000);
    expect_line("miss_a");
    check("miss_b_ready", wr_ready, 1'b1);
    model_write(32'h4000, 32'hCAFE_F00D, 4'hF);
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    check("miss_b_taken", idle, 1'b0);
    pulse_flush();
    push_line();
    expect_line("miss_b");

    // Overwrite of the same bytes by a later store.
    do_write("ovw1", 32'h6000, 32'h1111_1111, 4'hF, 1'b0);
    do_write("ovw2", 32'h6000, 32'h2222_2222, 4'h3, 1'b0);
    pulse_flush();
    push_line();
    #1;
    check("ovw_word0", line_data[255:224], 32'h1111_2222);
    expect_line("ovw");

    // Zero-strobe store captures the address only.
    do_write("zstrb", 32'h5004, 32'hFFFF_FFFF, 4'h0, 1'b0);
    check("zstrb_fill", idle, 1'b0);
    check("zstrb_mask", line_wmask, 32'h0);
    pulse_flush();
    push_line();
    expect_line("zstrb");

    // Reset during FILL discards the partial line.
    for (int i = 0; i < 3; i++)
      do_write("rstfill", 32'h7000 + 32'(4*i), 32'h55 + 32'(i), 4'hF, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
    check("rstfill_idle", idle, 1'b1);
    check("rstfill_mask", line_wmask, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seen = seen | line_valid;
    end
    check("rstfill_no_line", seen, 1'b0);

    // Flush coinciding with the completing eighth word yields one full line.
    for (int i = 0; i < 7; i++)
      do_write("fl8", 32'h8000 + 32'(4*i), 32'hC0 + 32'(i), 4'hF, 1'b0);
    do_write("fl8_last", 32'h801C, 32'hC7, 4'hF, 1'b1);
    push_line();
    expect_line("fl8");
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seen = seen | line_valid;
    end
    check("fl8_single_line", seen, 1'b0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
